// File: rtl/mips_dcache.sv
// mips_dcache: direct-mapped, write-back, write-allocate data cache with 256-bit lines.
// A flush sequencer writes back every dirty line and invalidates the whole array.
module mips_dcache #(
    parameter int unsigned INDEX_BITS = 6
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [31:0]  data_address_2DC,
    input  logic         read_2DC,
    input  logic         write_2DC,
    input  logic [31:0]  data_write_2DC,
    input  logic [1:0]   data_write_size_2DC,
    output logic [31:0]  data_read_fDC,
    output logic         data_valid_fDC,
    input  logic         flush_2DC,
    output logic         flush_done,
    output logic [31:0]  block_address_2DM,
    output logic [255:0] block_write_2DM,
    output logic         dBlkRead,
    output logic         dBlkWrite,
    input  logic [255:0] block_read_fDM,
    input  logic         block_read_fDM_valid,
    input  logic         block_write_fDM_valid
);
    localparam int unsigned TAG_W  = 27 - INDEX_BITS;
    localparam int unsigned NLINES = 1 << INDEX_BITS;

    typedef enum logic [2:0] {IDLE, WB, FILL, FL_SCAN, FL_WB} state_t;

    state_t                state_q, state_d;
    logic [INDEX_BITS-1:0] scan_q, scan_d;
    logic [NLINES-1:0]     valid_q, valid_d;
    logic [NLINES-1:0]     dirty_q, dirty_d;
    logic [TAG_W-1:0]      tag_q  [NLINES];
    logic [255:0]          data_q [NLINES];

    logic [4:0]            req_off;
    logic [INDEX_BITS-1:0] req_idx;
    logic [TAG_W-1:0]      req_tag;
    logic [255:0]          req_line, scan_line, merged_line, line_wdata;
    logic [31:0]           req_word;
    logic                  req, hit, line_we, fill_we;

    assign req_off   = data_address_2DC[4:0];
    assign req_idx   = data_address_2DC[INDEX_BITS+4:5];
    assign req_tag   = data_address_2DC[31:INDEX_BITS+5];
    assign req_line  = data_q[req_idx];
    assign scan_line = data_q[scan_q];
    assign req_word  = req_line[{req_off[4:2], 5'b00000} +: 32];
    assign req       = read_2DC | write_2DC;
    assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    // Store merge: source bytes are taken MSB-first from the low wr_bytes bytes
    // of the store data; destination bytes beyond the end of the line are dropped.
    logic [2:0] wr_bytes;
    logic [5:0] bpos;
    logic [1:0] src;
    logic [7:0] dst_lo;

    always_comb begin
        merged_line = req_line;
        wr_bytes    = (data_write_size_2DC == 2'd0) ? 3'd4 : {1'b0, data_write_size_2DC};
        bpos        = '0;
        src         = '0;
        dst_lo      = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            bpos   = {1'b0, req_off} + 6'(k);
            src    = 2'(wr_bytes - 3'(k) - 3'd1);
            dst_lo = {bpos[4:2], ~bpos[1:0], 3'b000};
            if ((3'(k) < wr_bytes) && !bpos[5])
                merged_line[dst_lo +: 8] = data_write_2DC[{src, 3'b000} +: 8];
        end
    end

    always_comb begin
        state_d           = state_q;
        scan_d            = scan_q;
        valid_d           = valid_q;
        dirty_d           = dirty_q;
        line_we           = 1'b0;
        fill_we           = 1'b0;
        line_wdata        = merged_line;
        data_read_fDC     = '0;
        data_valid_fDC    = 1'b0;
        flush_done        = 1'b0;
        block_address_2DM = '0;
        block_write_2DM   = '0;
        dBlkRead          = 1'b0;
        dBlkWrite         = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (flush_2DC) begin
                    state_d = FL_SCAN;
                    scan_d  = '0;
                end else if (req) begin
                    if (hit) begin
                        data_valid_fDC = 1'b1;
                        data_read_fDC  = req_word;
                        if (write_2DC) begin
                            line_we          = 1'b1;
                            dirty_d[req_idx] = 1'b1;
                        end
                    end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
                        state_d = WB;
                    end else begin
                        state_d = FILL;
                    end
                end else begin
                    data_valid_fDC = 1'b1;
                end
            end
            WB: begin
                dBlkWrite         = 1'b1;
                block_address_2DM = {tag_q[req_idx], req_idx, 5'b00000};
                block_write_2DM   = req_line;
                if (block_write_fDM_valid) begin
                    dirty_d[req_idx] = 1'b0;
                    state_d          = FILL;
                end
            end
            FILL: begin
                dBlkRead          = 1'b1;
                block_address_2DM = {data_address_2DC[31:5], 5'b00000};
                if (block_read_fDM_valid) begin
                    line_we          = 1'b1;
                    fill_we          = 1'b1;
                    line_wdata       = block_read_fDM;
                    valid_d[req_idx] = 1'b1;
                    dirty_d[req_idx] = 1'b0;
                    state_d          = IDLE;
                end
            end
            FL_SCAN: begin
                if (valid_q[scan_q] && dirty_q[scan_q]) begin
                    state_d = FL_WB;
                end else begin
                    valid_d[scan_q] = 1'b0;
                    if (&scan_q) begin
                        flush_done = 1'b1;
                        scan_d     = '0;
                        state_d    = IDLE;
                    end else begin
                        scan_d = scan_q + INDEX_BITS'(1);
                    end
                end
            end
            FL_WB: begin
                dBlkWrite         = 1'b1;
                block_address_2DM = {tag_q[scan_q], scan_q, 5'b00000};
                block_write_2DM   = scan_line;
                // Return to the same index so the now-clean line is invalidated there.
                if (block_write_fDM_valid) begin
                    dirty_d[scan_q] = 1'b0;
                    state_d         = FL_SCAN;
                end
            end
            default: state_d = IDLE;
        endcase

        if (!RESET) begin
            data_read_fDC  = '0;
            data_valid_fDC = 1'b1;
            flush_done     = 1'b0;
            dBlkRead       = 1'b0;
            dBlkWrite      = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            scan_q  <= '0;
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            state_q <= state_d;
            scan_q  <= scan_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (line_we) data_q[req_idx] <= line_wdata;
        if (fill_we) tag_q[req_idx]  <= req_tag;
    end

endmodule

// File: doc/mips_dcache.md
Name: mips_dcache

Overview:
- Direct-mapped, write-back, write-allocate data cache between the MEM stage and data memory.
- Replaces the current pass-through path:
  - MEM-side word/byte accesses are served from cached 256-bit lines.
  - Misses and write-backs use the block interface (dBlkRead/dBlkWrite).
  - data_valid_fDC stalls the pipeline while the cache is busy.
- A flush request (driven with SYS) writes back all dirty lines and invalidates the cache before a syscall proceeds.

Parameters:
- INDEX_BITS, 6, log2 of the line count (64 lines of 32 bytes). Tag width is 27-INDEX_BITS.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- data_address_2DC  in  32  byte address from MEM.
- read_2DC  in  1  read request.
- write_2DC  in  1  write request.
- data_write_2DC  in  32  store data; the low-order bytes are used.
- data_write_size_2DC  in  2  bytes to write: 1, 2, 3, or 0 meaning 4.
- data_read_fDC  out  32  read data.
- data_valid_fDC  out  1  request completes this cycle; 0 stalls MEM.
- flush_2DC  in  1  level request: write back all dirty lines, then invalidate everything.
- flush_done  out  1  one-cycle pulse when a flush completes.
- block_address_2DM  out  32  line address {addr[31:5],5'b0}.
- block_write_2DM  out  256  victim line data.
- dBlkRead  out  1  block read request.
- dBlkWrite  out  1  block write request.
- block_read_fDM  in  256  fill data.
- block_read_fDM_valid  in  1  fill accepted; data valid this cycle.
- block_write_fDM_valid  in  1  write-back accepted this cycle.

Behaviour:
- Address split: offset = addr[4:0], index = addr[INDEX_BITS+4:5], tag = addr[31:INDEX_BITS+5].
- Line layout: word w occupies bits [32w+31:32w]. Byte b within a word is big-endian, so byte 0 is bits [31:24].
- Per-line state: valid, dirty, tag, 256-bit data.
- Reset (RESET=0, asynchronous):
  - All valid and dirty bits clear; state = IDLE.
  - dBlkRead, dBlkWrite and flush_done are 0; data_read_fDC = 0; data_valid_fDC = 1.
  - Reset asserted mid-transfer abandons the transfer immediately. Any in-flight fill is discarded.
- FSM states: IDLE, WB, FILL, FL_SCAN, FL_WB.
- IDLE, no request: data_valid_fDC = 1.
- IDLE, hit:
  - data_valid_fDC = 1 in the same cycle (combinational tag compare).
  - Read: data_read_fDC = word addr[4:2] of the line.
  - Write: size bytes go to line bytes offset..offset+size-1 on the clock edge. They come from the least-significant size bytes of data_write_2DC, most significant first. Bytes past byte 31 are dropped. dirty is set.
- IDLE, miss:
  - data_valid_fDC = 0.
  - Victim valid and dirty: go to WB. Otherwise go to FILL.
- WB:
  - dBlkWrite = 1; block_address_2DM = {victim tag, index, 5'b0}; block_write_2DM = victim data.
  - All three are held stable until block_write_fDM_valid = 1, then clear dirty and go to FILL.
- FILL:
  - dBlkRead = 1; block_address_2DM = requested line address.
  - Hold until block_read_fDM_valid = 1, then install block_read_fDM with valid = 1, dirty = 0, new tag, and return to IDLE.
  - The still-held request then hits the next cycle, so minimum miss latency is 2 cycles.
- Simultaneous read_2DC and write_2DC: treated as a write. data_read_fDC still shows the pre-write word.
- Flush:
  - flush_2DC sampled in IDLE takes precedence over a pending access; data_valid_fDC = 0 throughout.
  - FL_SCAN walks index 0..2^INDEX_BITS-1, one line per cycle.
  - A valid dirty line goes to FL_WB, using the same handshake as WB, then returns to FL_SCAN at the same index.
  - Each visited line is invalidated after any write-back.
  - After the last index: flush_done pulses for 1 cycle and the state returns to IDLE.
  - If flush_2DC is still high in IDLE with no dirty lines, the scan repeats (harmless). The driver deasserts flush_2DC on flush_done.
- Only one of dBlkRead/dBlkWrite is ever high. Both are 0 in IDLE and FL_SCAN.
- The index counter wraps only at flush end; no other counters.

Test Plan:
- Cold read 0x00001004:
  - Expect data_valid_fDC = 0, then FILL with dBlkRead = 1 and block_address_2DM = 0x00001000.
  - Return block word1 = 0xDEADBEEF with valid after 3 cycles.
  - Next cycle: data_valid_fDC = 1, data_read_fDC = 0xDEADBEEF. dBlkWrite is never asserted.
- Write hit, size 1, data 0x000000AB to 0x00001005: line word1 becomes 0xDEABBEEF and the line is marked dirty.
  - A subsequent read of 0x00001004 returns 0xDEABBEEF in 1 cycle.
- Conflict miss on 0x00003004 (same index, line dirty):
  - WB with block_address_2DM = 0x00001000, word1 = 0xDEABBEEF, dBlkWrite held for 4 cycles until valid.
  - Then FILL at 0x00003000; the request completes.
- Size 0 (4-byte) store 0x11223344 to 0x0000101C, then a size-3 store 0x00AABBCC to 0x0000101E:
  - Word7 = 0x1122AABB. Byte 0xCC is dropped because it falls past byte 31.
- Flush with 2 dirty lines at indices 0 and 5:
  - Exactly 2 dBlkWrite handshakes, at the correct addresses.
  - flush_done pulses once, after index 63 is scanned.
  - A subsequent read of any previously cached address misses.
- RESET low during FILL:
  - dBlkRead drops asynchronously.
  - After release: state IDLE, all lines invalid, data_valid_fDC = 1.
